unified_mem_arbiter: RTL and testbench

//  Shares one single-port, variable-latency memory between the IF stage (instruction fetch) and the MEM stage (load/store).

---
 rtl/unified_mem_arbiter_if.sv | 22 ++
 rtl/unified_mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// Memory-side req/ack bus shared by the IF and MEM stages through the arbiter.
interface unified_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port variable-latency memory between instruction fetch
// and load/store, stalling the whole pipeline until each pending access is served.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       if_req,
  input  logic [ADDR_W-1:0]          if_addr,
  output logic [DATA_W-1:0]          if_rdata,
  output logic                       if_valid,
  input  logic                       dm_read,
  input  logic                       dm_write,
  input  logic [ADDR_W-1:0]          dm_addr,
  input  logic [DATA_W-1:0]          dm_wdata,
  output logic [DATA_W-1:0]          dm_rdata,
  output logic                       dm_done,
  output logic                       stall,
  unified_mem_arbiter_if.master      mem,
  output logic                       err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DM_BUSY = 2'd1,
    IF_BUSY = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              if_served_q, if_served_d;
  logic              dm_served_q, dm_served_d;
  logic              err_q, err_d;

  logic dm_pend, if_pend;
  logic busy, xfer_done, timed_out;
  logic dm_pend_upd, if_pend_upd;
  logic grant, grant_dm;

  assign dm_pend = (dm_read | dm_write) & ~dm_served_q;
  assign if_pend = if_req & ~if_served_q;
  assign stall   = dm_pend | if_pend;

  // A transfer retires on ack, or on timeout once the counter hits its last value.
  assign busy      = (state_q != IDLE);
  assign xfer_done = busy & mem_req_q & (mem.mem_ack | (cnt_q == CNT_LAST));
  assign timed_out = xfer_done & ~mem.mem_ack;

  // Pending terms as they will look once the retiring transfer is marked served.
  assign dm_pend_upd = dm_pend & ~(xfer_done & (state_q == DM_BUSY));
  assign if_pend_upd = if_pend & ~(xfer_done & (state_q == IF_BUSY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (dm_pend)      state_d = DM_BUSY;
        else if (if_pend) state_d = IF_BUSY;
      end
      DM_BUSY, IF_BUSY: begin
        if (xfer_done) begin
          if (dm_pend_upd)      state_d = DM_BUSY;
          else if (if_pend_upd) state_d = IF_BUSY;
          else                  state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant    = (state_d != IDLE) & (~busy | xfer_done);
  assign grant_dm = (state_d == DM_BUSY);

  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    cnt_d       = cnt_q;
    if_served_d = if_served_q;
    dm_served_d = dm_served_q;
    err_d       = err_q;

    // Busy with req low is the one-cycle launch gap after a back-to-back grant.
    if (busy) begin
      if (!mem_req_q) begin
        mem_req_d = 1'b1;
      end else if (xfer_done) begin
        mem_req_d = 1'b0;
        if (timed_out) err_d = 1'b1;
        if (state_q == DM_BUSY) begin
          dm_served_d = 1'b1;
          if (!mem_we_q) dm_rdata_d = timed_out ? '0 : mem.mem_rdata;
        end else begin
          if_served_d = 1'b1;
          if_rdata_d  = timed_out ? '0 : mem.mem_rdata;
        end
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (grant) begin
      cnt_d       = '0;
      mem_we_d    = grant_dm & dm_write;
      mem_addr_d  = grant_dm ? dm_addr : if_addr;
      mem_wdata_d = (grant_dm & dm_write) ? dm_wdata : '0;
      if (!busy) mem_req_d = 1'b1;
      if (grant_dm & dm_read & dm_write) err_d = 1'b1;
    end

    // The pipeline advances on any stall-free edge, which consumes the served results.
    if (!stall) begin
      if_served_d = 1'b0;
      dm_served_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      cnt_q       <= '0;
      if_served_q <= 1'b0;
      dm_served_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      cnt_q       <= cnt_d;
      if_served_q <= if_served_d;
      dm_served_q <= dm_served_d;
      err_q       <= err_d;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign if_rdata      = if_rdata_q;
  assign dm_rdata      = dm_rdata_q;
  assign if_valid      = if_served_q;
  assign dm_done       = dm_served_q;
  assign err           = err_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: table of single-shot pipeline accesses
// against a delay-programmable memory responder, plus a mid-transaction reset.
module tb_unified_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        stall;
  logic        err;

  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .dm_read  (dm_read),
    .dm_write (dm_write),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_done  (dm_done),
    .stall    (stall),
    .mem      (mem_bus.master),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: rd_word = 32'h8C22_0004;
      32'h0000_0104: rd_word = 32'h0022_1820;
      32'h0000_0040: rd_word = 32'hDEAD_BEEF;
      default:       rd_word = a ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Memory responder: acks ack_dly cycles after req rises (-1 = never) and logs every transfer.
  int          ack_dly = -1;
  int          hi_cnt = 0;
  int          low_cnt = 0;
  int          stab_err = 0;
  bit          prev_req = 1'b0;
  logic [31:0] h_addr, h_wd;
  logic        h_we;
  logic [31:0] addr_q[$];
  logic [31:0] wd_q[$];
  logic        we_q[$];
  int          hi_q[$];
  int          gap_q[$];

  initial begin
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 32'h0;
  end

  always @(negedge clk) begin
    if (mem_bus.mem_req) begin
      if (!prev_req) begin
        addr_q.push_back(mem_bus.mem_addr);
        wd_q.push_back(mem_bus.mem_wdata);
        we_q.push_back(mem_bus.mem_we);
        gap_q.push_back(low_cnt);
        h_addr = mem_bus.mem_addr;
        h_wd   = mem_bus.mem_wdata;
        h_we   = mem_bus.mem_we;
        hi_cnt = 0;
      end else if (mem_bus.mem_addr !== h_addr || mem_bus.mem_wdata !== h_wd ||
                   mem_bus.mem_we !== h_we) begin
        stab_err++;
      end
      mem_bus.mem_ack   = (ack_dly >= 0) && (hi_cnt == ack_dly);
      mem_bus.mem_rdata = mem_bus.mem_ack ? rd_word(mem_bus.mem_addr) : 32'h0BAD_0BAD;
      hi_cnt++;
      low_cnt = 0;
    end else begin
      if (prev_req) hi_q.push_back(hi_cnt);
      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = 32'h0BAD_0BAD;
      low_cnt++;
    end
    prev_req = mem_bus.mem_req;
  end

  typedef struct {
    bit          do_rst;
    bit          if_req;
    logic [31:0] if_addr;
    bit          dm_read;
    bit          dm_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    int          ack_dly;
    int          exp_ntx;
    logic [31:0] exp_addr0;
    bit          exp_we0;
    logic [31:0] exp_wd0;
    int          exp_hi0;
    int          exp_gap1;
    int          exp_stall;
    bit          exp_ifv;
    bit          exp_dmd;
    logic [31:0] exp_ifr;
    logic [31:0] exp_dmr;
    bit          exp_err;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs[NV];

  task automatic run_vec(input int id, input vec_t v);
    int    base_a, base_h, base_g, stall_cyc, ntx, hv;
    bit    done;
    string tag;
    tag = $sformatf("v%0d", id);
    if (v.do_rst) begin
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
    end
    @(negedge clk);
    #1;
    base_a   = addr_q.size();
    base_h   = hi_q.size();
    base_g   = gap_q.size();
    ack_dly  = v.ack_dly;
    if_req   = v.if_req;
    if_addr  = v.if_addr;
    dm_read  = v.dm_read;
    dm_write = v.dm_write;
    dm_addr  = v.dm_addr;
    dm_wdata = v.dm_wdata;
    stall_cyc = 0;
    done      = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1'b1;
        break;
      end
      stall_cyc++;
    end
    #1;
    chk({tag, "_stall_released"}, 32'(done), 32'd1);
    chk({tag, "_stall_cycles"}, 32'(stall_cyc), 32'(v.exp_stall));
    ntx = addr_q.size() - base_a;
    chk({tag, "_ntx"}, 32'(ntx), 32'(v.exp_ntx));
    chk({tag, "_addr0"}, (ntx > 0) ? addr_q[base_a] : 32'hFFFF_FFFF, v.exp_addr0);
    chk({tag, "_we0"}, (ntx > 0) ? 32'(we_q[base_a]) : 32'hFFFF_FFFF, 32'(v.exp_we0));
    chk({tag, "_wdata0"}, (ntx > 0) ? wd_q[base_a] : 32'hFFFF_FFFF, v.exp_wd0);
    hv = (hi_q.size() > base_h) ? hi_q[base_h] : -1;
    chk({tag, "_req_cycles0"}, 32'(hv), 32'(v.exp_hi0));
    if (v.exp_ntx == 2)
      chk({tag, "_req_gap"}, (gap_q.size() > base_g + 1) ? 32'(gap_q[base_g+1]) : 32'hFFFF_FFFF,
          32'(v.exp_gap1));
    chk({tag, "_if_valid"}, 32'(if_valid), 32'(v.exp_ifv));
    chk({tag, "_dm_done"}, 32'(dm_done), 32'(v.exp_dmd));
    chk({tag, "_if_rdata"}, if_rdata, v.exp_ifr);
    chk({tag, "_dm_rdata"}, dm_rdata, v.exp_dmr);
    chk({tag, "_err"}, 32'(err), 32'(v.exp_err));
    chk({tag, "_mem_req_idle"}, 32'(mem_bus.mem_req), 32'd0);
    if_req   = 1'b0;
    dm_read  = 1'b0;
    dm_write = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_if_valid_clr"}, 32'(if_valid), 32'd0);
    chk({tag, "_dm_done_clr"}, 32'(dm_done), 32'd0);
    chk({tag, "_stall_idle"}, 32'(stall), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t hv;
    rst_n    = 1'b0;
    if_req   = 1'b0;
    if_addr  = 32'h0;
    dm_read  = 1'b0;
    dm_write = 1'b0;
    dm_addr  = 32'h0;
    dm_wdata = 32'h0;

    //        rst if  if_addr       rd wr dm_addr       dm_wdata      dly ntx addr0         we wd0           hi gap st ifv dmd if_rdata      dm_rdata      err
    vecs[0] = '{0, 1, 32'h0000_0100, 0, 0, 32'h0,        32'h0,         2, 1, 32'h0000_0100, 0, 32'h0,        3, 0, 3, 1, 0, 32'h8C22_0004, 32'h0,        0};
    vecs[1] = '{0, 1, 32'h0000_0104, 1, 0, 32'h0000_0040, 32'h0,        1, 2, 32'h0000_0040, 0, 32'h0,        2, 1, 5, 1, 1, 32'h0022_1820, 32'hDEAD_BEEF, 0};
    vecs[2] = '{0, 0, 32'h0,         0, 1, 32'h0000_0080, 32'h1234_5678, 3, 1, 32'h0000_0080, 1, 32'h1234_5678, 4, 0, 4, 0, 1, 32'h0022_1820, 32'hDEAD_BEEF, 0};
    vecs[3] = '{0, 0, 32'h0,         1, 0, 32'h0000_0200, 32'h0,       -1, 1, 32'h0000_0200, 0, 32'h0,        8, 0, 8, 0, 1, 32'h0022_1820, 32'h0,        1};
    vecs[4] = '{1, 0, 32'h0,         1, 1, 32'h0000_0084, 32'hCAFE_F00D, 1, 1, 32'h0000_0084, 1, 32'hCAFE_F00D, 2, 0, 2, 0, 1, 32'h0,        32'h0,        1};
    vecs[5] = '{0, 1, 32'h0000_0108, 0, 0, 32'h0,        32'h0,         0, 1, 32'h0000_0108, 0, 32'h0,        1, 0, 1, 1, 0, 32'h5A5A_0108, 32'h0,        1};

    #12;
    chk("rst_mem_req", 32'(mem_bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_bus.mem_we), 32'd0);
    chk("rst_mem_addr", mem_bus.mem_addr, 32'h0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_req", 32'(mem_bus.mem_req), 32'd0);

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Reset three cycles into a load that is never acked.
    @(negedge clk);
    ack_dly = -1;
    dm_read = 1'b1;
    dm_addr = 32'h0000_0300;
    repeat (3) @(negedge clk);
    chk("mid_req_high", 32'(mem_bus.mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_req", 32'(mem_bus.mem_req), 32'd0);
    chk("mid_rst_mem_addr", mem_bus.mem_addr, 32'h0);
    chk("mid_rst_if_rdata", if_rdata, 32'h0);
    chk("mid_rst_if_valid", 32'(if_valid), 32'd0);
    chk("mid_rst_dm_done", 32'(dm_done), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    dm_read = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_stall", 32'(stall), 32'd0);
    hv = '{0, 1, 32'h0000_0100, 0, 0, 32'h0, 32'h0, 1, 1, 32'h0000_0100, 0, 32'h0, 2, 0, 2, 1, 0,
           32'h8C22_0004, 32'h0, 0};
    run_vec(6, hv);

    chk("bus_stable_while_req", 32'(stab_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
